rtc_bus_sequencer: RTL and testbench

- Sequences every transfer between the time/date/timer register bank and the external parallel RTC over a multiplexed address/data bus (chip select, read strobe, write strobe, address/data select).
- Two requesters share the bus: a write-all burst, raised after the processor loads new values, and a read-all burst, raised on a periodic refresh tick.
- Arbitrates between them, walks the nine RTC registers in a fixed order and generates strobe timing.
- Signals completion with one-cycle pulses that the register bank uses as its ready flags.

---
 rtl/rtc_bus_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// ---------------------------------------------------------------------------
// rtc_bus_sequencer
//
// Moves the nine time/date/timer registers between the register bank and an
// external parallel RTC over a multiplexed address/data bus. Two requesters
// share the bus: a write-all burst and a read-all burst. Write requests take
// priority. Each register goes through an address phase, a gap, a data phase
// and a second gap, and each phase lasts T_PH cycles. A write burst ends with
// an address-only command cycle that commits the new values inside the RTC.
//
// Ports
//   clk, reset           system clock, asynchronous active-high reset
//   start_wr, start_rd   request pulses (latched, merged while pending)
//   wr_byte              bank data for the current reg_sel
//   reg_sel              index 0..8 of the register being transferred
//   rd_byte, rd_strobe   captured RTC byte and its one-cycle valid pulse
//   ad_out, ad_in, ad_oe multiplexed bus data/address and output enable
//   cs_n, rd_n, wr_n     RTC chip select and strobes, active low
//   a_d                  0 = address phase, 1 = data phase
//   busy                 burst in progress
//   listo_es, listo_le   write-all / read-all complete pulses
// ---------------------------------------------------------------------------
module rtc_bus_sequencer #(
  parameter int unsigned T_PH         = 8,
  parameter logic [7:0]  CMD_TRANSFER = 8'hF1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_wr,
  input  logic       start_rd,
  input  logic [7:0] wr_byte,
  output logic [3:0] reg_sel,
  output logic [7:0] rd_byte,
  output logic       rd_strobe,
  output logic [7:0] ad_out,
  input  logic [7:0] ad_in,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic       busy,
  output logic       listo_es,
  output logic       listo_le
);

  localparam logic [7:0] PH_LAST  = 8'(T_PH - 1);
  localparam logic [3:0] SEL_LAST = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2, S_NEXT, S_CMD, S_CMD_GAP
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       last_ph;
  logic       is_wr;
  logic       pend_wr, pend_rd;
  logic [3:0] reg_sel_nxt;
  logic       burst_end;

  // RTC address of each bank register, in transfer order.
  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    reg_addr = 8'h21;
      4'd1:    reg_addr = 8'h22;
      4'd2:    reg_addr = 8'h23;
      4'd3:    reg_addr = 8'h24;
      4'd4:    reg_addr = 8'h25;
      4'd5:    reg_addr = 8'h26;
      4'd6:    reg_addr = 8'h41;
      4'd7:    reg_addr = 8'h42;
      4'd8:    reg_addr = 8'h43;
      default: reg_addr = 8'h00;
    endcase
  endfunction

  assign last_ph   = (cnt == PH_LAST);
  assign burst_end = (state != S_IDLE) && (state_nxt == S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pend_wr || pend_rd) state_nxt = S_ADDR;
      S_ADDR:    if (last_ph) state_nxt = S_GAP1;
      S_GAP1:    if (last_ph) state_nxt = S_DATA;
      S_DATA:    if (last_ph) state_nxt = S_GAP2;
      S_GAP2:    if (last_ph) state_nxt = S_NEXT;
      S_NEXT: begin
        if (reg_sel != SEL_LAST) state_nxt = S_ADDR;
        else if (is_wr)          state_nxt = S_CMD;
        else                     state_nxt = S_IDLE;
      end
      S_CMD:     if (last_ph) state_nxt = S_CMD_GAP;
      S_CMD_GAP: if (last_ph) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // reg_sel advances on the way back into ADDR so it stays stable through
  // the rd_strobe cycle of the register just read.
  always_comb begin
    reg_sel_nxt = reg_sel;
    if (state_nxt == S_IDLE)
      reg_sel_nxt = 4'd0;
    else if (state == S_NEXT && state_nxt == S_ADDR)
      reg_sel_nxt = reg_sel + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      pend_wr   <= 1'b0;
      pend_rd   <= 1'b0;
      reg_sel   <= '0;
      rd_byte   <= '0;
      rd_strobe <= 1'b0;
      ad_out    <= '0;
      ad_oe     <= 1'b0;
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      a_d       <= 1'b1;
      busy      <= 1'b0;
      listo_es  <= 1'b0;
      listo_le  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= (state_nxt != state || state == S_IDLE) ? '0 : cnt + 8'd1;
      reg_sel <= reg_sel_nxt;
      busy    <= (state_nxt != S_IDLE);

      // Requests merge into the pending flags; the granted flag is dropped on
      // the grant cycle, which also absorbs a repeat arriving that cycle.
      pend_wr <= pend_wr | start_wr;
      pend_rd <= pend_rd | start_rd;
      if (state == S_IDLE && state_nxt == S_ADDR) begin
        is_wr <= pend_wr;
        if (pend_wr) pend_wr <= 1'b0;
        else         pend_rd <= 1'b0;
      end

      listo_es <= burst_end && is_wr;
      listo_le <= burst_end && !is_wr;

      rd_strobe <= 1'b0;
      if (state == S_DATA && last_ph && !is_wr) begin
        rd_byte   <= ad_in;
        rd_strobe <= 1'b1;
      end

      // Bus pins are registered from the state being entered.
      cs_n   <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      a_d    <= 1'b1;
      ad_oe  <= 1'b0;
      ad_out <= '0;
      case (state_nxt)
        S_ADDR: begin
          cs_n   <= 1'b0;
          wr_n   <= 1'b0;
          a_d    <= 1'b0;
          ad_oe  <= 1'b1;
          ad_out <= reg_addr(reg_sel_nxt);
        end
        S_CMD: begin
          cs_n   <= 1'b0;
          wr_n   <= 1'b0;
          a_d    <= 1'b0;
          ad_oe  <= 1'b1;
          ad_out <= CMD_TRANSFER;
        end
        S_DATA: begin
          cs_n <= 1'b0;
          if (is_wr) begin
            wr_n   <= 1'b0;
            ad_oe  <= 1'b1;
            ad_out <= wr_byte;
          end else begin
            rd_n <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
module tb_rtc_bus_sequencer;

  localparam int NI  = 2;
  localparam int TP0 = 8;
  localparam int TP1 = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_wr = 1'b0;
  logic       start_rd = 1'b0;
  logic [7:0] ad_in = 8'h00;
  logic [7:0] wr_tbl [16];
  logic [7:0] wr_byte0, wr_byte1;

  logic [3:0]    reg_sel_v [NI];
  logic [7:0]    rd_byte_v [NI];
  logic [7:0]    ad_out_v  [NI];
  logic [NI-1:0] rd_strobe_v, ad_oe_v, cs_n_v, rd_n_v, wr_n_v, a_d_v;
  logic [NI-1:0] busy_v, listo_es_v, listo_le_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign wr_byte0 = wr_tbl[reg_sel_v[0]];
  assign wr_byte1 = wr_tbl[reg_sel_v[1]];

  rtc_bus_sequencer #(.T_PH(TP0), .CMD_TRANSFER(8'hF1)) u_dut8 (
    .clk(clk), .reset(reset), .start_wr(start_wr), .start_rd(start_rd),
    .wr_byte(wr_byte0), .reg_sel(reg_sel_v[0]), .rd_byte(rd_byte_v[0]),
    .rd_strobe(rd_strobe_v[0]), .ad_out(ad_out_v[0]), .ad_in(ad_in),
    .ad_oe(ad_oe_v[0]), .cs_n(cs_n_v[0]), .rd_n(rd_n_v[0]), .wr_n(wr_n_v[0]),
    .a_d(a_d_v[0]), .busy(busy_v[0]), .listo_es(listo_es_v[0]),
    .listo_le(listo_le_v[0]));

  rtc_bus_sequencer #(.T_PH(TP1), .CMD_TRANSFER(8'hF1)) u_dut2 (
    .clk(clk), .reset(reset), .start_wr(start_wr), .start_rd(start_rd),
    .wr_byte(wr_byte1), .reg_sel(reg_sel_v[1]), .rd_byte(rd_byte_v[1]),
    .rd_strobe(rd_strobe_v[1]), .ad_out(ad_out_v[1]), .ad_in(ad_in),
    .ad_oe(ad_oe_v[1]), .cs_n(cs_n_v[1]), .rd_n(rd_n_v[1]), .wr_n(wr_n_v[1]),
    .a_d(a_d_v[1]), .busy(busy_v[1]), .listo_es(listo_es_v[1]),
    .listo_le(listo_le_v[1]));

  // RTC address list in transfer order.
  logic [7:0] rtc_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                               8'h41, 8'h42, 8'h43};

  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t",
               name, inst, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: a burst is a position k counted from its first
  // ADDR cycle; all outputs follow from k by arithmetic on phase lengths.
  // ------------------------------------------------------------------
  int         tp   [NI] = '{TP0, TP1};
  bit         m_inb[NI], m_w[NI], m_pw[NI], m_pr[NI], m_es[NI], m_le[NI];
  int         m_k  [NI];
  logic [7:0] m_rdb[NI];

  function automatic int burst_len(input int t, input bit w);
    return 9 * (4 * t + 1) + (w ? 2 * t : 0);
  endfunction

  task automatic model_step(input int n);
    bit npw, npr;
    int b;
    b = 4 * tp[n] + 1;
    if (reset) begin
      m_inb[n] = 0; m_w[n] = 0; m_pw[n] = 0; m_pr[n] = 0;
      m_es[n] = 0; m_le[n] = 0; m_k[n] = 0; m_rdb[n] = 8'h00;
      return;
    end
    npw = m_pw[n] | start_wr;
    npr = m_pr[n] | start_rd;
    m_es[n] = 0;
    m_le[n] = 0;
    if (!m_inb[n]) begin
      if (m_pw[n] || m_pr[n]) begin
        m_inb[n] = 1;
        m_w[n]   = m_pw[n];
        m_k[n]   = 0;
        if (m_pw[n]) npw = 0; else npr = 0;
      end
    end else begin
      m_k[n]++;
      if (m_k[n] == burst_len(tp[n], m_w[n])) begin
        m_inb[n] = 0;
        m_es[n]  = m_w[n];
        m_le[n]  = !m_w[n];
      end else if (!m_w[n] && m_k[n] < 9 * b && (m_k[n] % b) == 3 * tp[n]) begin
        m_rdb[n] = ad_in;
      end
    end
    m_pw[n] = npw;
    m_pr[n] = npr;
  endtask

  task automatic compare_inst(input int n);
    logic e_cs, e_rd, e_wr, e_ad, e_oe, e_busy, e_stb;
    logic [3:0] e_sel;
    logic [7:0] e_out;
    int t, b, i, r, j;
    t = tp[n]; b = 4 * t + 1;
    e_cs = 1; e_rd = 1; e_wr = 1; e_ad = 1; e_oe = 0; e_busy = 0; e_stb = 0;
    e_sel = 4'd0; e_out = 8'h00;
    if (m_inb[n]) begin
      e_busy = 1;
      if (m_k[n] < 9 * b) begin
        i = m_k[n] / b;
        r = m_k[n] % b;
        e_sel = 4'(i);
        if (r < t) begin
          e_cs = 0; e_wr = 0; e_ad = 0; e_oe = 1; e_out = rtc_addr[i];
        end else if (r >= 2 * t && r < 3 * t) begin
          e_cs = 0;
          if (m_w[n]) begin e_wr = 0; e_oe = 1; e_out = wr_tbl[i]; end
          else e_rd = 0;
        end else if (r == 3 * t) begin
          e_stb = !m_w[n];
        end
      end else begin
        j = m_k[n] - 9 * b;
        e_sel = 4'd8;
        if (j < t) begin
          e_cs = 0; e_wr = 0; e_ad = 0; e_oe = 1; e_out = 8'hF1;
        end
      end
    end
    chk("cs_n", n, 32'(cs_n_v[n]), 32'(e_cs));
    chk("rd_n", n, 32'(rd_n_v[n]), 32'(e_rd));
    chk("wr_n", n, 32'(wr_n_v[n]), 32'(e_wr));
    chk("a_d", n, 32'(a_d_v[n]), 32'(e_ad));
    chk("ad_oe", n, 32'(ad_oe_v[n]), 32'(e_oe));
    if (e_oe) chk("ad_out", n, 32'(ad_out_v[n]), 32'(e_out));
    chk("busy", n, 32'(busy_v[n]), 32'(e_busy));
    chk("reg_sel", n, 32'(reg_sel_v[n]), 32'(e_sel));
    chk("rd_strobe", n, 32'(rd_strobe_v[n]), 32'(e_stb));
    chk("rd_byte", n, 32'(rd_byte_v[n]), 32'(m_rdb[n]));
    chk("listo_es", n, 32'(listo_es_v[n]), 32'(m_es[n]));
    chk("listo_le", n, 32'(listo_le_v[n]), 32'(m_le[n]));
    chk("strobe_excl", n, 32'(!rd_n_v[n] && !wr_n_v[n]), 32'd0);
    chk("strobe_cs", n, 32'(cs_n_v[n] && (!rd_n_v[n] || !wr_n_v[n])), 32'd0);
  endtask

  // Event bookkeeping for the directed expectations.
  int         cyc = 0;
  int         n_stb[NI], n_es[NI], n_le[NI], n_rdlow[NI];
  int         rise_cyc[NI], le_cyc[NI], es_cyc[NI], gap_es[NI];
  bit         p_busy[NI], p_addr[NI];
  logic [7:0] addr_q[$];

  initial begin
    for (int n = 0; n < NI; n++) begin
      n_stb[n] = 0; n_es[n] = 0; n_le[n] = 0; n_rdlow[n] = 0;
      rise_cyc[n] = 0; le_cyc[n] = 0; es_cyc[n] = 0; gap_es[n] = -1;
      p_busy[n] = 0; p_addr[n] = 0;
      m_inb[n] = 0; m_w[n] = 0; m_pw[n] = 0; m_pr[n] = 0;
      m_es[n] = 0; m_le[n] = 0; m_k[n] = 0; m_rdb[n] = 8'h00;
    end
    forever begin
      @(posedge clk);
      for (int n = 0; n < NI; n++) model_step(n);
      cyc++;
      #1;
      for (int n = 0; n < NI; n++) begin
        compare_inst(n);
        n_stb[n]   += int'(rd_strobe_v[n]);
        n_es[n]    += int'(listo_es_v[n]);
        n_le[n]    += int'(listo_le_v[n]);
        n_rdlow[n] += int'(!rd_n_v[n]);
        if (listo_es_v[n]) es_cyc[n] = cyc;
        if (listo_le_v[n]) le_cyc[n] = cyc;
        if (busy_v[n] && !p_busy[n]) begin
          rise_cyc[n] = cyc;
          gap_es[n]   = cyc - es_cyc[n];
        end
        p_busy[n] = busy_v[n];
      end
      if (ad_oe_v[0] && !a_d_v[0] && !p_addr[0]) addr_q.push_back(ad_out_v[0]);
      p_addr[0] = ad_oe_v[0] && !a_d_v[0];
    end
  end

  // Bus input: fixed value or fresh random byte each cycle.
  bit         ad_rand = 0;
  logic [7:0] ad_fix = 8'h00;
  initial forever begin
    @(negedge clk);
    ad_in = ad_rand ? 8'($urandom) : ad_fix;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input bit w, input bit r);
    @(negedge clk);
    start_wr = w;
    start_rd = r;
    @(negedge clk);
    start_wr = 0;
    start_rd = 0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((m_inb[0] || m_inb[1] || m_pw[0] || m_pr[0] || m_pw[1] || m_pr[1])
           && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_idle_timeout", 0, 32'(c >= budget), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  int s_stb[NI], s_es[NI], s_le[NI], s_rdlow;
  logic [7:0] exp_seq [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                               8'h41, 8'h42, 8'h43, 8'hF1};

  task automatic snap();
    for (int n = 0; n < NI; n++) begin
      s_stb[n] = n_stb[n]; s_es[n] = n_es[n]; s_le[n] = n_le[n];
    end
    s_rdlow = n_rdlow[0];
  endtask

  initial begin
    int c;
    for (int i = 0; i < 16; i++) wr_tbl[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      chk("rst_cs_n", n, 32'(cs_n_v[n]), 32'd1);
      chk("rst_a_d", n, 32'(a_d_v[n]), 32'd1);
      chk("rst_ad_oe", n, 32'(ad_oe_v[n]), 32'd0);
      chk("rst_busy", n, 32'(busy_v[n]), 32'd0);
      chk("rst_rd_byte", n, 32'(rd_byte_v[n]), 32'd0);
    end
    reset = 0;
    repeat (3) @(negedge clk);

    // Read-all with a constant bus value
    ad_rand = 0;
    ad_fix  = 8'h43;
    snap();
    pulse(0, 1);
    wait_idle(2000);
    chk("t1_strobes", 0, 32'(n_stb[0] - s_stb[0]), 32'd9);
    chk("t1_strobes", 1, 32'(n_stb[1] - s_stb[1]), 32'd9);
    chk("t1_listo_le", 0, 32'(n_le[0] - s_le[0]), 32'd1);
    chk("t1_latency", 0, 32'(le_cyc[0] - rise_cyc[0]), 32'd297);
    chk("t1_latency", 1, 32'(le_cyc[1] - rise_cyc[1]), 32'd81);
    chk("t1_rd_byte", 0, 32'(rd_byte_v[0]), 32'h43);

    // Write-all with constant bank data
    ad_rand = 1;
    for (int i = 0; i < 16; i++) wr_tbl[i] = 8'h99;
    addr_q.delete();
    snap();
    pulse(1, 0);
    wait_idle(2000);
    chk("t2_addr_count", 0, 32'(addr_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < addr_q.size(); i++)
      chk("t2_addr_seq", 0, 32'(addr_q[i]), 32'(exp_seq[i]));
    chk("t2_rd_low", 0, 32'(n_rdlow[0] - s_rdlow), 32'd0);
    chk("t2_listo_es", 0, 32'(n_es[0] - s_es[0]), 32'd1);

    // Simultaneous requests: write first, read right after
    for (int i = 0; i < 16; i++) wr_tbl[i] = 8'($urandom);
    snap();
    pulse(1, 1);
    wait_idle(3000);
    for (int n = 0; n < NI; n++) begin
      chk("t3_listo_es", n, 32'(n_es[n] - s_es[n]), 32'd1);
      chk("t3_listo_le", n, 32'(n_le[n] - s_le[n]), 32'd1);
      chk("t3_rd_after_es", n, 32'(gap_es[n]), 32'd1);
    end

    // Repeated read requests during a write burst merge into one
    snap();
    pulse(1, 0);
    repeat (20) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      pulse(0, 1);
      repeat (10) @(negedge clk);
    end
    wait_idle(3000);
    for (int n = 0; n < NI; n++) begin
      chk("t4_listo_es", n, 32'(n_es[n] - s_es[n]), 32'd1);
      chk("t4_listo_le", n, 32'(n_le[n] - s_le[n]), 32'd1);
    end

    // Reset during DATA of reg_sel 4 aborts the write
    pulse(1, 0);
    c = 0;
    while (!(m_inb[0] && m_w[0] && m_k[0] == 4 * (4 * TP0 + 1) + 2 * TP0 + 3)
           && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("t5_reach_data", 0, 32'(c >= 1000), 32'd0);
    chk("t5_pre_wr_n", 0, 32'(wr_n_v[0]), 32'd0);
    chk("t5_pre_sel", 0, 32'(reg_sel_v[0]), 32'd4);
    snap();
    reset = 1;
    #1;
    chk("t5_cs_n", 0, 32'(cs_n_v[0]), 32'd1);
    chk("t5_wr_n", 0, 32'(wr_n_v[0]), 32'd1);
    chk("t5_ad_oe", 0, 32'(ad_oe_v[0]), 32'd0);
    chk("t5_busy", 0, 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    repeat (20) @(negedge clk);
    chk("t5_no_listo_es", 0, 32'(n_es[0] - s_es[0]), 32'd0);
    addr_q.delete();
    pulse(1, 0);
    wait_idle(2000);
    chk("t5_restart_addr", 0, 32'(addr_q.size() > 0 ? addr_q[0] : 8'h00), 32'h21);
    chk("t5_listo_es", 0, 32'(n_es[0] - s_es[0]), 32'd1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      c = int'($urandom_range(0, 59));
      start_wr = (c == 0) || (c == 2);
      start_rd = (c == 1) || (c == 2);
    end
    @(negedge clk);
    start_wr = 0;
    start_rd = 0;
    wait_idle(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
